sync_fifo_gen2: RTL and testbench
=================================

// Module: sync_fifo_gen2
// PURPOSE
//  Parametrised single-clock FIFO; successor to the fixed 8x16 FIFO. Adds configurable width/depth,
//  first-word-fall-through (FWFT) mode, programmable almost-full/empty flags, fill-level output,
//  synchronous flush and sticky error flags. Used as the generic buffer between datapath stages.
// PARAMETERS
//  DATA_WIDTH  8   payload width in bits (>=1)
//  DEPTH       16  number of entries (>=2, need not be a power of two)
//  AF_LEVEL    14  almost_full asserted when level >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL    2   almost_empty asserted when level <= AE_LEVEL (0..DEPTH-1)
//  FWFT        0   0 = registered read (1-cycle latency); 1 = first-word-fall-through
// PORTS
//  clk           in   1                   clock, rising edge
//  rst_n         in   1                   reset, asynchronous, active-low
//  flush         in   1                   synchronous clear of contents
//  wr_en         in   1                   write request
//  wr_data       in   DATA_WIDTH          write payload
//  rd_en         in   1                   read request (FWFT=1: pop/acknowledge of head)
//  rd_data       out  DATA_WIDTH          read payload
//  rd_valid      out  1                   rd_data holds valid data
//  full, empty   out  1 each              level==DEPTH / level==0
//  almost_full   out  1                   level >= AF_LEVEL
//  almost_empty  out  1                   level <= AE_LEVEL
//  level         out  $clog2(DEPTH+1)     current occupancy
//  overflow      out  1                   1-cycle pulse: wr_en while full (previous cycle)
//  underflow     out  1                   1-cycle pulse: rd_en while empty (previous cycle)
//  err_sticky    out  2                   {ovf,udf} sticky, set with pulses, cleared by err_clr
//  err_clr       in   1                   clears err_sticky (set wins if same cycle)
// BEHAVIOUR
//  - Reset: pointers, level, rd_data=0, rd_valid=0, overflow/underflow=0, err_sticky=0;
//    hence empty=1, almost_empty=1, full=0, almost_full=(AF_LEVEL==0 ? n/a : 0).
//  - Write accepted iff wr_en && !full; read accepted iff rd_en && !empty. Flags decode from
//    registered level (combinational, no extra latency).
//  - Pointers wrap DEPTH-1 -> 0 explicitly. Level: +1 write-only, -1 read-only, unchanged both.
//  - Full + wr_en + rd_en: read accepted, write rejected, overflow pulses. Empty + wr_en + rd_en:
//    write accepted, read rejected, underflow pulses (no bypass in either mode).
//  - FWFT=0: accepted read registers mem[rptr] into rd_data next edge; rd_valid pulses that cycle;
//    rd_data holds last value otherwise.
//  - FWFT=1: rd_data = mem[rptr] whenever !empty, rd_valid = !empty; rd_en pops head. A word
//    written into an empty FIFO is visible the cycle after the write edge.
//  - flush: highest priority after reset; next edge clears pointers/level, discards same-cycle
//    wr/rd, forces rd_valid=0; does not touch err_sticky or generate error pulses.
//  - Reset mid-operation: all contents logically discarded; memory array is not reset.
//  - Memory array has no reset; written only on accepted writes.
// STRUCTURE
//  - Package fifo_pkg: default width/depth constants, level-width function clog2(DEPTH+1),
//    error-bit index constants ERR_OVF=1, ERR_UDF=0.
//  - One sub-module: fifo_ram (simple dual-port, sync write, async read; rd register in parent).
//  - Parameter legality (AF_LEVEL/AE_LEVEL ranges, DEPTH>=2) checked at elaboration.
// TESTING
//  1 Reset then fill DEPTH=16 with 0x00..0x0F -> full=1 after 16th write, level=16,
//    almost_full rose at level 14; 17th write -> overflow pulse, err_sticky[1]=1, data intact.
//  2 Drain 16 (FWFT=0) -> rd_data 0x00..0x0F one cycle after each rd_en; empty=1 after last;
//    extra rd_en -> underflow pulse, rd_valid=0.
//  3 Wrap: DEPTH=5, write 3/read 3 repeatedly for 20 words -> order preserved across wrap.
//  4 Simultaneous wr+rd at level 0, mid (8) and full (16) -> level 1 / 8 / 15 as specified.
//  5 FWFT=1: write 0xA5 into empty -> rd_valid=1, rd_data=0xA5 next cycle without rd_en;
//    rd_en pops, empty=1.
//  6 flush at level 9 with wr_en=1 -> level=0, empty=1, no write stored; err_clr + overflow
//    same cycle -> sticky remains 1; rst_n low mid-burst -> all outputs to reset values async.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the generic single-clock FIFO family.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 16;

  // Bit positions inside err_sticky.
  localparam int ERR_OVF = 1;
  localparam int ERR_UDF = 0;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: storage is deliberately not reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_gen2.sv
// Parametrised single-clock FIFO with optional first-word-fall-through,
// programmable almost flags, flush and sticky error reporting.
module sync_fifo_gen2
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_valid,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [level_width(DEPTH)-1:0] level,
  output logic                          overflow,
  output logic                          underflow,
  output logic [1:0]                    err_sticky,
  input  logic                          err_clr
);

  localparam int LW = level_width(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_gen2: DEPTH must be >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_gen2: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_gen2: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [PW-1:0]         wptr, rptr;
  logic [LW-1:0]         level_q, level_d;
  logic                  wr_acc, rd_acc, ovf_evt, udf_evt;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign full         = (level_q == LW'(DEPTH));
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= LW'(AF_LEVEL));
  assign almost_empty = (level_q <= LW'(AE_LEVEL));
  assign level        = level_q;

  // Flush suppresses both transfers and error events for its cycle.
  assign wr_acc  = wr_en && !full  && !flush;
  assign rd_acc  = rd_en && !empty && !flush;
  assign ovf_evt = wr_en && full  && !flush;
  assign udf_evt = rd_en && empty && !flush;

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (PW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr),
    .wdata (wr_data),
    .raddr (rptr),
    .rdata (ram_rdata)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    level_d = level_q;
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      level_q <= '0;
    end else if (flush) begin
      wptr    <= '0;
      rptr    <= '0;
      level_q <= '0;
    end else begin
      if (wr_acc) wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
      if (rd_acc) rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
      level_q <= level_d;
    end
  end

  // A new error event outranks err_clr in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      err_sticky <= '0;
    end else begin
      overflow            <= ovf_evt;
      underflow           <= udf_evt;
      err_sticky[ERR_OVF] <= (err_sticky[ERR_OVF] && !err_clr) || ovf_evt;
      err_sticky[ERR_UDF] <= (err_sticky[ERR_UDF] && !err_clr) || udf_evt;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign rd_data  = empty ? '0 : ram_rdata;
    assign rd_valid = !empty;
  end else begin : g_reg_read
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_acc;
        if (rd_acc) rd_data <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_gen2.sv
// Directed bench for sync_fifo_gen2: 16-deep registered, 5-deep wrap and FWFT instances.
module tb_sync_fifo_gen2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance a: DEPTH=16, FWFT=0, AF=14, AE=2
  logic       a_flush = 0, a_wr = 0, a_rd = 0, a_clr = 0;
  logic [7:0] a_wd = '0, a_rdata;
  logic       a_rv, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
  logic [4:0] a_lvl;
  logic [1:0] a_err;

  sync_fifo_gen2 #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .wr_en(a_wr), .wr_data(a_wd), .rd_en(a_rd),
    .rd_data(a_rdata), .rd_valid(a_rv), .full(a_full), .empty(a_empty), .almost_full(a_af),
    .almost_empty(a_ae), .level(a_lvl), .overflow(a_ovf), .underflow(a_udf),
    .err_sticky(a_err), .err_clr(a_clr));

  // Instance b: DEPTH=5 (not a power of two), FWFT=0
  logic       b_flush = 0, b_wr = 0, b_rd = 0, b_clr = 0;
  logic [7:0] b_wd = '0, b_rdata;
  logic       b_rv, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
  logic [2:0] b_lvl;
  logic [1:0] b_err;

  sync_fifo_gen2 #(.DATA_WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(0)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .wr_en(b_wr), .wr_data(b_wd), .rd_en(b_rd),
    .rd_data(b_rdata), .rd_valid(b_rv), .full(b_full), .empty(b_empty), .almost_full(b_af),
    .almost_empty(b_ae), .level(b_lvl), .overflow(b_ovf), .underflow(b_udf),
    .err_sticky(b_err), .err_clr(b_clr));

  // Instance c: DEPTH=4, FWFT=1
  logic       c_flush = 0, c_wr = 0, c_rd = 0, c_clr = 0;
  logic [7:0] c_wd = '0, c_rdata;
  logic       c_rv, c_full, c_empty, c_af, c_ae, c_ovf, c_udf;
  logic [2:0] c_lvl;
  logic [1:0] c_err;

  sync_fifo_gen2 #(.DATA_WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(c_flush), .wr_en(c_wr), .wr_data(c_wd), .rd_en(c_rd),
    .rd_data(c_rdata), .rd_valid(c_rv), .full(c_full), .empty(c_empty), .almost_full(c_af),
    .almost_empty(c_ae), .level(c_lvl), .overflow(c_ovf), .underflow(c_udf),
    .err_sticky(c_err), .err_clr(c_clr));

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({a_empty, a_ae, a_full, a_af, a_rv, a_ovf, a_udf} !== 7'b1100000) begin
      failures++; $display("FAIL reset_flags_a: got %b required 1100000",
                           {a_empty, a_ae, a_full, a_af, a_rv, a_ovf, a_udf});
    end
    checks++;
    if (a_lvl !== 5'd0 || a_rdata !== 8'h00 || a_err !== 2'b00) begin
      failures++; $display("FAIL reset_state_a: lvl=%0d rdata=%h err=%b required 0/00/00",
                           a_lvl, a_rdata, a_err);
    end
    checks++;
    if (c_rv !== 1'b0 || c_empty !== 1'b1 || c_rdata !== 8'h00) begin
      failures++; $display("FAIL reset_fwft: rv=%b empty=%b rdata=%h required 0/1/00",
                           c_rv, c_empty, c_rdata);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      a_wr = 1'b1; a_wd = 8'(i);
      step();
      checks++;
      if (a_lvl !== 5'(i + 1) || a_af !== (i + 1 >= 14) || a_full !== (i + 1 == 16)) begin
        failures++; $display("FAIL fill_%0d: lvl=%0d af=%b full=%b required lvl=%0d af=%b full=%b",
                             i, a_lvl, a_af, a_full, i + 1, (i + 1 >= 14), (i + 1 == 16));
      end
    end
    a_wd = 8'hEE;
    step();
    a_wr = 1'b0;
    checks++;
    if (a_ovf !== 1'b1 || a_err !== 2'b10 || a_lvl !== 5'd16) begin
      failures++; $display("FAIL fill_overflow: ovf=%b err=%b lvl=%0d required 1/10/16",
                           a_ovf, a_err, a_lvl);
    end
    step();
    checks++;
    if (a_ovf !== 1'b0) begin
      failures++; $display("FAIL overflow_pulse_width: ovf=%b required 0", a_ovf);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      a_rd = 1'b1;
      step();
      checks++;
      if (a_rv !== 1'b1 || a_rdata !== 8'(i) || a_lvl !== 5'(15 - i) || a_ae !== (15 - i <= 2)) begin
        failures++; $display("FAIL drain_%0d: rv=%b rdata=%h lvl=%0d ae=%b required 1/%h/%0d/%b",
                             i, a_rv, a_rdata, a_lvl, a_ae, 8'(i), 15 - i, (15 - i <= 2));
      end
    end
    checks++;
    if (a_empty !== 1'b1) begin
      failures++; $display("FAIL drain_empty: empty=%b required 1", a_empty);
    end
    step();
    a_rd = 1'b0;
    checks++;
    if (a_udf !== 1'b1 || a_rv !== 1'b0 || a_err !== 2'b11 || a_rdata !== 8'h0F) begin
      failures++; $display("FAIL drain_underflow: udf=%b rv=%b err=%b rdata=%h required 1/0/11/0f",
                           a_udf, a_rv, a_err, a_rdata);
    end
    step();
    checks++;
    if (a_udf !== 1'b0) begin
      failures++; $display("FAIL underflow_pulse_width: udf=%b required 0", a_udf);
    end
  endtask

  task automatic test_wrap();
    int k = 0;
    int n;
    while (k < 20) begin
      n = (20 - k < 3) ? 20 - k : 3;
      for (int j = 0; j < n; j++) begin
        b_wr = 1'b1; b_wd = 8'(8'h40 + k + j);
        step();
      end
      b_wr = 1'b0;
      for (int j = 0; j < n; j++) begin
        b_rd = 1'b1;
        step();
        checks++;
        if (b_rv !== 1'b1 || b_rdata !== 8'(8'h40 + k + j)) begin
          failures++; $display("FAIL wrap_word_%0d: rv=%b rdata=%h required 1/%h",
                               k + j, b_rv, b_rdata, 8'(8'h40 + k + j));
        end
      end
      b_rd = 1'b0;
      k += n;
    end
    checks++;
    if (b_empty !== 1'b1 || b_lvl !== 3'd0) begin
      failures++; $display("FAIL wrap_end: empty=%b lvl=%0d required 1/0", b_empty, b_lvl);
    end
  endtask

  task automatic test_simultaneous();
    // Empty: write taken, read rejected with underflow.
    a_clr = 1'b1; step(); a_clr = 1'b0;
    a_wr = 1'b1; a_rd = 1'b1; a_wd = 8'h30;
    step();
    a_rd = 1'b0;
    checks++;
    if (a_lvl !== 5'd1 || a_udf !== 1'b1 || a_rv !== 1'b0) begin
      failures++; $display("FAIL simul_empty: lvl=%0d udf=%b rv=%b required 1/1/0", a_lvl, a_udf, a_rv);
    end
    for (int i = 1; i < 8; i++) begin
      a_wd = 8'(8'h30 + i); step();
    end
    a_rd = 1'b1; a_wd = 8'h38;
    step();
    checks++;
    if (a_lvl !== 5'd8 || a_rv !== 1'b1 || a_rdata !== 8'h30) begin
      failures++; $display("FAIL simul_mid: lvl=%0d rv=%b rdata=%h required 8/1/30", a_lvl, a_rv, a_rdata);
    end
    a_rd = 1'b0;
    for (int i = 9; i < 17; i++) begin
      a_wd = 8'(8'h30 + i); step();
    end
    checks++;
    if (a_lvl !== 5'd16 || a_full !== 1'b1) begin
      failures++; $display("FAIL simul_fill: lvl=%0d full=%b required 16/1", a_lvl, a_full);
    end
    // Full: read taken, write rejected; err_clr lands with the overflow event.
    a_rd = 1'b1; a_clr = 1'b1; a_wd = 8'hEE;
    step();
    a_wr = 1'b0; a_rd = 1'b0; a_clr = 1'b0;
    checks++;
    if (a_lvl !== 5'd15 || a_ovf !== 1'b1 || a_rdata !== 8'h31 || a_err !== 2'b10) begin
      failures++; $display("FAIL simul_full: lvl=%0d ovf=%b rdata=%h err=%b required 15/1/31/10",
                           a_lvl, a_ovf, a_rdata, a_err);
    end
  endtask

  task automatic test_flush();
    a_rd = 1'b1;
    for (int i = 0; i < 6; i++) step();
    a_rd = 1'b0;
    checks++;
    if (a_lvl !== 5'd9 || a_rdata !== 8'h37) begin
      failures++; $display("FAIL flush_setup: lvl=%0d rdata=%h required 9/37", a_lvl, a_rdata);
    end
    a_flush = 1'b1; a_wr = 1'b1; a_wd = 8'hFF;
    step();
    a_flush = 1'b0; a_wr = 1'b0;
    checks++;
    if (a_lvl !== 5'd0 || a_empty !== 1'b1 || a_rv !== 1'b0 || a_ovf !== 1'b0 || a_err !== 2'b10) begin
      failures++; $display("FAIL flush: lvl=%0d empty=%b rv=%b ovf=%b err=%b required 0/1/0/0/10",
                           a_lvl, a_empty, a_rv, a_ovf, a_err);
    end
    a_wr = 1'b1; a_wd = 8'h77; step(); a_wr = 1'b0;
    a_rd = 1'b1; step(); a_rd = 1'b0;
    checks++;
    if (a_rdata !== 8'h77 || a_empty !== 1'b1) begin
      failures++; $display("FAIL flush_after: rdata=%h empty=%b required 77/1", a_rdata, a_empty);
    end
  endtask

  task automatic test_fwft();
    c_wr = 1'b1; c_wd = 8'hA5;
    step();
    c_wr = 1'b0;
    checks++;
    if (c_rv !== 1'b1 || c_rdata !== 8'hA5 || c_empty !== 1'b0) begin
      failures++; $display("FAIL fwft_show: rv=%b rdata=%h empty=%b required 1/a5/0", c_rv, c_rdata, c_empty);
    end
    c_wr = 1'b1; c_wd = 8'h5A;
    step();
    c_wr = 1'b0;
    checks++;
    if (c_rdata !== 8'hA5 || c_lvl !== 3'd2) begin
      failures++; $display("FAIL fwft_hold: rdata=%h lvl=%0d required a5/2", c_rdata, c_lvl);
    end
    c_rd = 1'b1;
    step();
    checks++;
    if (c_rv !== 1'b1 || c_rdata !== 8'h5A) begin
      failures++; $display("FAIL fwft_pop1: rv=%b rdata=%h required 1/5a", c_rv, c_rdata);
    end
    step();
    c_rd = 1'b0;
    checks++;
    if (c_rv !== 1'b0 || c_empty !== 1'b1) begin
      failures++; $display("FAIL fwft_pop2: rv=%b empty=%b required 0/1", c_rv, c_empty);
    end
  endtask

  task automatic test_async_reset();
    a_wr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_wd = 8'(8'h90 + i); step();
    end
    a_rd = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (a_lvl !== 5'd0 || a_empty !== 1'b1 || a_ae !== 1'b1 || a_rv !== 1'b0 ||
        a_rdata !== 8'h00 || a_err !== 2'b00 || a_ovf !== 1'b0 || a_udf !== 1'b0) begin
      failures++; $display("FAIL async_reset: lvl=%0d empty=%b ae=%b rv=%b rdata=%h err=%b required 0/1/1/0/00/00",
                           a_lvl, a_empty, a_ae, a_rv, a_rdata, a_err);
    end
    a_wr = 1'b0; a_rd = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    checks++;
    if (a_lvl !== 5'd0 || a_rv !== 1'b0) begin
      failures++; $display("FAIL after_reset: lvl=%0d rv=%b required 0/0", a_lvl, a_rv);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_fwft();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
